uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler sharing one uart_main transmitter among N_REQ requesters.
//  Each requester offers a W_OUT-bit word with valid/ready. The block grants one, pulses
//  s_valid into uart_main, tracks tx_ready through the frame, then enforces an inter-frame gap.
//  Sits between the packet sources and the uart_main s_valid/s_data/tx_ready port.
// PARAMETERS
//  N_REQ        4    number of requesters (2..8)
//  W_OUT        16   word width sent per grant (matches uart_main W_OUT)
//  GAP_CYCLES   32   idle clk cycles forced after each frame completes (0 = no gap)
//  ACK_TIMEOUT  64   max cycles waiting for tx_ready to drop after s_valid pulse
// PORTS
//  clk          in   1             system clock
//  rst          in   1             synchronous reset, active-high
//  req_valid    in   N_REQ         requester i has a word pending
//  req_data     in   N_REQ*W_OUT   word of requester i at bits [i*W_OUT +: W_OUT]
//  req_ready    out  N_REQ         one-hot accept pulse: word i taken this cycle
//  s_valid      out  1             to uart_main: 1-cycle start pulse
//  s_data       out  W_OUT         to uart_main: word being sent, held stable until frame done
//  tx_ready     in   1             from uart_main: 1 = transmitter idle
//  grant_id     out  $clog2(N_REQ) index of requester currently/last served
//  busy         out  1             1 in any state other than IDLE
//  timeout_err  out  1             sticky: tx_ready never dropped after a start pulse
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, req_ready=0, s_valid=0, s_data=0, grant_id=0,
//   busy=0, timeout_err=0, rr pointer=0, counters=0. Reset mid-frame aborts immediately.
//  States: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> GAP -> IDLE.
//  IDLE: if any req_valid and tx_ready=1: pick first valid index at or after rr pointer,
//   wrapping modulo N_REQ. Register its data into s_data, set grant_id, pulse req_ready[i]
//   for exactly one cycle, and go to ISSUE. If tx_ready=0, wait in IDLE.
//  ISSUE: s_valid=1 for exactly this one cycle. rr pointer <= grant_id+1, wrapping to 0
//   past N_REQ-1. Go to WAIT_ACK. Latency from req_valid at IDLE to s_valid is 2 cycles.
//  WAIT_ACK: count cycles. On tx_ready=0, go to WAIT_DONE.
//   If the count reaches ACK_TIMEOUT, set timeout_err=1 and go to GAP. The word is dropped.
//  WAIT_DONE: wait for tx_ready=1, then go to GAP.
//  GAP: hold GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, go straight to IDLE.
//  s_data holds its value from the grant until the next grant; it does not change in
//   ISSUE/WAIT_*/GAP.
//  req_ready is never asserted to a requester whose req_valid=0. At most one bit is set.
//  Requester may drop req_valid before it is granted; nothing is latched for it.
//  Simultaneous requests: strict round-robin. The last-served index has lowest priority next.
//  A requester that holds req_valid continuously cannot be starved: it is served within
//   N_REQ grants.
//  timeout_err clears only on rst.
// TESTING
//  T1 single: after reset, req_valid=4'b0001, data0=16'hA55A -> req_ready[0] pulse,
//   s_valid 2 cycles later, uart_main loopback m_data=16'hA55A, busy low after frame+gap.
//  T2 all four valid with data 16'h1111/2222/3333/4444 -> grants in order 0,1,2,3.
//   Each s_valid is spaced by at least frame+GAP_CYCLES; loopback matches each word.
//  T3 wrap: grant 3, then req_valid=4'b1001 -> next grant is 0, then 3.
//  T4 timeout: hold tx_ready=1 (model stuck) -> timeout_err=1 exactly ACK_TIMEOUT cycles
//   after s_valid. State returns to IDLE after the gap. Sticky until rst.
//  T5 reset mid-frame: assert rst during WAIT_DONE -> next cycle s_valid=0, busy=0,
//   grant_id=0. The next request is served from index 0.
//  T6 tx_ready=0 at idle (external user) with req_valid=4'b0010 -> no grant until
//   tx_ready=1, then req_ready[1] pulses.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one uart_main transmitter among N_REQ requesters,
// issuing a one-cycle start pulse per granted word and enforcing an inter-frame gap.
module uart_tx_scheduler #(
  parameter int N_REQ       = 4,
  parameter int W_OUT       = 16,
  parameter int GAP_CYCLES  = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W_OUT-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       s_valid,
  output logic [W_OUT-1:0]           s_data,
  input  logic                       tx_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int ID_W    = $clog2(N_REQ);
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   scan;
  logic              found;
  logic              grant;
  logic              timeout_set;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  // First valid requester at or after the round-robin pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = ID_W'((int'(rr) + k) % N_REQ);
      if (!found && req_valid[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  assign grant     = (state == IDLE) && tx_ready && found;
  assign req_ready = grant ? (N_REQ'(1) << pick) : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = WAIT_ACK;
        cnt_nxt   = '0;
      end
      WAIT_ACK: begin
        if (!tx_ready) begin
          state_nxt = WAIT_DONE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Transmitter never took the word: drop it and fall through to the gap.
          timeout_set = 1'b1;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
        else                               cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rr          <= '0;
      s_valid     <= 1'b0;
      s_data      <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // Start pulse is registered out of ISSUE, landing two cycles after the grant.
      s_valid <= (state == ISSUE);
      if (grant) begin
        s_data   <= req_data[pick*W_OUT +: W_OUT];
        grant_id <= pick;
      end
      if (state == ISSUE)
        rr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic checked
// against a cycle-level round-robin reference and a simple uart_main loopback model.
module tb_uart_tx_scheduler;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int GAP   = 5;
  localparam int ACK   = 20;
  localparam int FRAME = 10;
  localparam int HN    = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic          tx_ready;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  uart_tx_scheduler #(
    .N_REQ(N), .W_OUT(W), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .s_valid(s_valid), .s_data(s_data),
    .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // uart_main stand-in: takes s_data on s_valid, stays busy FRAME+1 cycles.
  logic        model_ready = 1'b1;
  logic        ext_ready   = 1'b1;
  logic        stuck       = 1'b0;
  int          fcnt        = 0;
  logic [W-1:0] loop_q[$];
  assign tx_ready = model_ready & ext_ready;

  always @(posedge clk) begin
    if (rst) begin
      model_ready <= 1'b1;
      fcnt        <= 0;
    end else if (model_ready) begin
      if (s_valid && !stuck) begin
        model_ready <= 1'b0;
        fcnt        <= FRAME;
        loop_q.push_back(s_data);
      end
    end else if (fcnt == 0) begin
      model_ready <= 1'b1;
    end else begin
      fcnt <= fcnt - 1;
    end
  end

  // Cycle history and event queues.
  int           cyc = 0;
  logic [N-1:0] hv [0:HN-1];
  logic [N-1:0] hr [0:HN-1];
  logic         ht [0:HN-1];
  logic         hs [0:HN-1];
  logic         hb [0:HN-1];
  logic         hto[0:HN-1];
  logic [N*W-1:0] hd [0:HN-1];
  int           gq[$];
  int           gcq[$];
  int           svq[$];

  always @(posedge clk) begin
    int idx;
    if (cyc < HN) begin
      hv[cyc] = req_valid; hr[cyc] = req_ready; ht[cyc] = tx_ready;
      hs[cyc] = s_valid;   hb[cyc] = busy;      hto[cyc] = timeout_err;
      hd[cyc] = req_data;
    end
    if (|req_ready) begin
      idx = -1;
      for (int i = N - 1; i >= 0; i--) if (req_ready[i]) idx = i;
      gq.push_back(idx);
      gcq.push_back(cyc);
    end
    if (s_valid) svq.push_back(cyc);
    cyc = cyc + 1;
  end

  logic [N-1:0] served = '0;
  int           gseen  = 0;

  task automatic clear_obs();
    gq.delete(); gcq.delete(); svq.delete(); loop_q.delete();
    gseen = 0; served = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Requesters hold valid until served once, then drop it.
  task automatic run(input logic [N-1:0] want, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      while (gseen < gq.size()) begin
        served = served | (N'(1) << gq[gseen]);
        gseen++;
      end
      req_valid = want & ~served;
    end
  endtask

  task automatic test_reset();
    do_reset(); clear_obs();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_s_valid got=%b want=0", s_valid); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_err); end
    total++; if (s_data !== 16'h0) begin bad++; $display("FAIL reset_s_data got=%h want=0", s_data); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
  endtask

  task automatic test_single();
    do_reset(); clear_obs();
    req_data = {48'h0, 16'hA55A};
    @(negedge clk); req_valid = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL t1_req_ready got=%b want=0001", req_ready); end
    @(negedge clk); req_valid = 4'b0000; #1;
    total++; if (s_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0) begin
      bad++; $display("FAIL t1_issue s_valid=%b busy=%b req_ready=%b want 0/1/0000", s_valid, busy, req_ready); end
    @(negedge clk); #1;
    total++; if (s_valid !== 1'b1 || s_data !== 16'hA55A || grant_id !== 2'd0) begin
      bad++; $display("FAIL t1_start s_valid=%b s_data=%h grant=%0d want 1/a55a/0", s_valid, s_data, grant_id); end
    for (int k = 3; k <= 5 + FRAME + GAP; k++) begin
      @(negedge clk); #1;
      total++; if (busy !== (k < 5 + FRAME + GAP)) begin
        bad++; $display("FAIL t1_busy cycle=%0d got=%b want=%b", k, busy, (k < 5 + FRAME + GAP)); end
    end
    total++; if (loop_q.size() != 1 || loop_q[0] !== 16'hA55A) begin
      bad++; $display("FAIL t1_loopback count=%0d want one word a55a", loop_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_w[4];
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_reset(); clear_obs();
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    run(4'b1111, 100);
    total++; if (gq.size() != 4) begin bad++; $display("FAIL t2_grant_count got=%0d want=4", gq.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) begin
        total++; if (gq[i] != i) begin bad++; $display("FAIL t2_order slot=%0d got=%0d want=%0d", i, gq[i], i); end
      end
      if (i < loop_q.size()) begin
        total++; if (loop_q[i] !== exp_w[i]) begin bad++; $display("FAIL t2_loopback slot=%0d got=%h want=%h", i, loop_q[i], exp_w[i]); end
      end
      if (i < svq.size() && i < gcq.size()) begin
        total++; if (svq[i] != gcq[i] + 2) begin bad++; $display("FAIL t2_latency slot=%0d got=%0d want=2", i, svq[i] - gcq[i]); end
      end
      if (i > 0 && i < svq.size()) begin
        total++; if (svq[i] - svq[i-1] < FRAME + 1 + GAP) begin
          bad++; $display("FAIL t2_spacing slot=%0d got=%0d want>=%0d", i, svq[i] - svq[i-1], FRAME + 1 + GAP); end
      end
    end
  endtask

  task automatic test_wrap();
    clear_obs();
    run(4'b1001, 60);
    total++; if (gq.size() != 2) begin bad++; $display("FAIL t3_count got=%0d want=2", gq.size()); end
    if (gq.size() >= 2) begin
      total++; if (gq[0] != 0 || gq[1] != 3) begin
        bad++; $display("FAIL t3_order got=%0d,%0d want=0,3", gq[0], gq[1]); end
    end
  endtask

  task automatic test_timeout();
    int t;
    do_reset(); clear_obs();
    stuck = 1'b1;
    req_data = {32'h0, 16'hBEEF, 16'h0};
    run(4'b0010, 60);
    total++; if (svq.size() != 1) begin bad++; $display("FAIL t4_pulses got=%0d want=1", svq.size()); end
    if (svq.size() >= 1) begin
      t = svq[0];
      total++; if (hto[t+ACK-1] !== 1'b0 || hto[t+ACK] !== 1'b1) begin
        bad++; $display("FAIL t4_timeout_edge before=%b at=%b want 0/1", hto[t+ACK-1], hto[t+ACK]); end
      total++; if (hb[t+ACK+GAP-1] !== 1'b1 || hb[t+ACK+GAP] !== 1'b0) begin
        bad++; $display("FAIL t4_gap_then_idle busy=%b,%b want 1,0", hb[t+ACK+GAP-1], hb[t+ACK+GAP]); end
    end
    stuck = 1'b0; clear_obs();
    req_data = {48'h0, 16'h1234};
    run(4'b0001, 40); #1;
    total++; if (loop_q.size() != 1 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL t4_sticky words=%0d timeout_err=%b want 1/1", loop_q.size(), timeout_err); end
    do_reset(); #1;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL t4_clear got=%b want=0", timeout_err); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(); clear_obs();
    req_data = {16'h3C3C, 16'h0, 16'h5151, 16'h0A0A};
    run(4'b0010, 6); #1;
    total++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      bad++; $display("FAIL t5_in_frame busy=%b tx_ready=%b want 1/0", busy, tx_ready); end
    @(negedge clk); rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0; #1;
    total++; if (s_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      bad++; $display("FAIL t5_after_reset s_valid=%b busy=%b grant=%0d want 0/0/0", s_valid, busy, grant_id); end
    clear_obs();
    run(4'b1001, 8);
    total++; if (gq.size() < 1 || gq[0] != 0) begin
      bad++; $display("FAIL t5_restart grants=%0d first=%0d want first=0", gq.size(), (gq.size() > 0) ? gq[0] : -1); end
  endtask

  task automatic test_tx_busy_idle();
    do_reset(); clear_obs();
    ext_ready = 1'b0;
    req_data = {32'h0, 16'h7777, 16'h0};
    run(4'b0010, 8); #1;
    total++; if (gq.size() != 0 || busy !== 1'b0 || req_ready !== 4'b0) begin
      bad++; $display("FAIL t6_hold grants=%0d busy=%b req_ready=%b want 0/0/0000", gq.size(), busy, req_ready); end
    @(negedge clk); ext_ready = 1'b1; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL t6_release got=%b want=0010", req_ready); end
    run(4'b0010, 30);
    total++; if (loop_q.size() != 1 || loop_q[0] !== 16'h7777) begin
      bad++; $display("FAIL t6_loopback words=%0d want one word 7777", loop_q.size()); end
  endtask

  task automatic test_random();
    logic [W-1:0] wbuf[N][8];
    int           head[N];
    int           len[N];
    logic [N-1:0] en;
    int           s, e, g, p, rr_m, next_ok, last_g;
    logic         wait_rise, saw_low;
    logic [N-1:0] exp_r;
    logic [W-1:0] expq[$];
    do_reset(); clear_obs();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 8; k++) wbuf[i][k] = 16'($urandom);
      len[i]  = $urandom_range(3, 8);
      head[i] = 0;
    end
    en = '1;
    s  = 0;
    for (int k = 0; k < 1300; k++) begin
      @(negedge clk);
      if (k == 0) s = cyc;
      while (gseen < gq.size()) begin
        g = gq[gseen]; gseen++;
        if (g >= 0 && len[g] > 0) begin head[g]++; len[g]--; end
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) en[i] = ~en[i];
        req_valid[i] = (len[i] > 0) && en[i] && (k < 1250);
        req_data[i*W +: W] = wbuf[i][(head[i] < 8) ? head[i] : 7];
      end
    end
    e = cyc;
    // Reference: grant on the first eligible cycle, round-robin from the last served index.
    rr_m = 0; wait_rise = 1'b0; saw_low = 1'b0; next_ok = s; last_g = -100;
    for (int c = s; c < e && c < HN; c++) begin
      exp_r = '0;
      if (!wait_rise && c >= next_ok && ht[c] === 1'b1 && |hv[c]) begin
        p = -1;
        for (int k = 0; k < N; k++) if (p < 0 && hv[c][(rr_m + k) % N]) p = (rr_m + k) % N;
        exp_r = N'(1) << p;
        rr_m = (p + 1) % N;
        wait_rise = 1'b1; saw_low = 1'b0; last_g = c;
        expq.push_back(16'(hd[c] >> (W * p)));
      end else if (wait_rise) begin
        if (ht[c] !== 1'b1) saw_low = 1'b1;
        else if (saw_low) begin wait_rise = 1'b0; next_ok = c + 1 + GAP; end
      end
      total++; if (hr[c] !== exp_r) begin
        bad++; $display("FAIL rnd_req_ready cycle=%0d got=%b want=%b", c, hr[c], exp_r); end
      total++; if (hs[c] !== (c == last_g + 2)) begin
        bad++; $display("FAIL rnd_s_valid cycle=%0d got=%b want=%b", c, hs[c], (c == last_g + 2)); end
    end
    total++; if (loop_q.size() != expq.size()) begin
      bad++; $display("FAIL rnd_word_count got=%0d want=%0d", loop_q.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < loop_q.size(); i++) begin
      total++; if (loop_q[i] !== expq[i]) begin
        bad++; $display("FAIL rnd_loopback slot=%0d got=%h want=%h", i, loop_q[i], expq[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_frame();
    test_tx_busy_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
